reg_wb_queue: RTL and testbench

Write-back queue that owns the write side of the 16×16 register file. Execution units push (address, data) write requests through a valid/ready handshake. The queue buffers them in order and drains at most one per cycle onto the register file's `Caddr`/`C`/`load` port. It also reports whether either register-file read address has a write still pending, so issue logic can stall on a read-after-write hazard.

---
 rtl/reg_wb_pkg.sv | 17 +
 rtl/wb_entry_fifo.sv | 57 +++++
 rtl/reg_wb_queue.sv | 76 +++++++
 tb/tb_reg_wb_queue.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_pkg.sv
// Shared defaults, entry layout and count-width helper for the register-file write-back queue.
package reg_wb_pkg;

    localparam int RWB_ADDR_W = 4;
    localparam int RWB_DATA_W = 16;

    typedef struct packed {
        logic [RWB_ADDR_W-1:0] addr;
        logic [RWB_DATA_W-1:0] data;
    } wb_entry_t;

    // Occupancy runs 0..depth inclusive, so it needs one bit more than a pointer.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_entry_fifo.sv
// In-order entry storage with head/tail pointers and occupancy; one cycle push-to-head.
// No internal backpressure: the caller never pushes into a full array or pops an empty one.
import reg_wb_pkg::*;

module wb_entry_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 20
) (
    input  logic                    clk,
    input  logic                    nClear,
    input  logic                    push,
    input  logic [W-1:0]            push_dat,
    input  logic                    pop,
    output logic [W-1:0]            head_dat,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic [DEPTH-1:0]        occ,
    output logic [DEPTH-1:0][W-1:0] entries
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;
    logic [DEPTH-1:0][W-1:0] mem;

    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign entries  = mem;

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ[i] = ({1'b0, PTR_W'(i) - rd_ptr} < count);
        end
    end

endmodule

// File: rtl/reg_wb_queue.sv
// Write-back queue owning the register-file write port; retires one write per cycle, one cycle after push.
// wr_ready drops only when full and held; REG_WB_HIT_EN builds the Ahit/Bhit read-after-write comparators.
import reg_wb_pkg::*;

module reg_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = RWB_ADDR_W,
    parameter int DATA_W = RWB_DATA_W
) (
    input  logic                    clk,
    input  logic                    nClear,
    input  logic                    wr_valid,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    output logic                    wr_ready,
    input  logic                    hold,
    output logic [ADDR_W-1:0]       Caddr,
    output logic [DATA_W-1:0]       C,
    output logic                    load,
    input  logic [ADDR_W-1:0]       Aaddr,
    input  logic [ADDR_W-1:0]       Baddr,
    output logic                    Ahit,
    output logic                    Bhit,
    output logic [cnt_w(DEPTH)-1:0] count
);

    localparam int W     = ADDR_W + DATA_W;
    localparam int CNT_W = cnt_w(DEPTH);

    logic                    push;
    logic                    full;
    logic [W-1:0]            head_dat;
    logic [DEPTH-1:0]        occ;
    logic [DEPTH-1:0][W-1:0] entries;

    assign full     = (count == CNT_W'(DEPTH));
    // A full queue that is draining this cycle frees the head slot at the same edge.
    assign wr_ready = !full || !hold;
    assign push     = wr_valid && wr_ready;
    assign load     = (count != '0) && !hold;
    assign Caddr    = load ? head_dat[W-1 -: ADDR_W] : '0;
    assign C        = load ? head_dat[DATA_W-1:0]    : '0;

    wb_entry_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk      (clk),
        .nClear   (nClear),
        .push     (push),
        .push_dat ({wr_addr, wr_data}),
        .pop      (load),
        .head_dat (head_dat),
        .count    (count),
        .occ      (occ),
        .entries  (entries)
    );

`ifdef REG_WB_HIT_EN
    // The head still counts: the read port samples on the same edge that commits it.
    always_comb begin
        Ahit = 1'b0;
        Bhit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ[i] && entries[i][W-1 -: ADDR_W] == Aaddr) Ahit = 1'b1;
            if (occ[i] && entries[i][W-1 -: ADDR_W] == Baddr) Bhit = 1'b1;
        end
    end
`else
    logic unused_hit_inputs;
    assign unused_hit_inputs = ^{Aaddr, Baddr, occ, entries};
    assign Ahit = 1'b0;
    assign Bhit = 1'b0;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Scoreboarded bench for reg_wb_queue: directed drain/hold/hazard/clear cases, then random traffic into a register-file model.
module tb_reg_wb_queue;
    import reg_wb_pkg::*;

`ifdef REG_WB_HIT_EN
    localparam logic HIT = 1'b1;
`else
    localparam logic HIT = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        nClear   = 1'b0;
    logic        wr_valid = 1'b0;
    logic [3:0]  wr_addr  = '0;
    logic [15:0] wr_data  = '0;
    logic        hold     = 1'b0;
    logic [3:0]  Aaddr    = '0;
    logic [3:0]  Baddr    = '0;
    logic        wr_ready;
    logic [3:0]  Caddr;
    logic [15:0] C;
    logic        load;
    logic        Ahit;
    logic        Bhit;
    logic [2:0]  count;

    int          n_tests = 0;
    int          n_fail  = 0;
    wb_entry_t   exp_q[$];
    wb_entry_t   mon_e;
    logic        mh_a;
    logic        mh_b;
    logic [15:0] rf_model [16];
    logic [15:0] ref_rf   [16];

    always #5 clk = ~clk;

    reg_wb_queue #(.DEPTH(4), .ADDR_W(4), .DATA_W(16)) dut (
        .clk      (clk),
        .nClear   (nClear),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .hold     (hold),
        .Caddr    (Caddr),
        .C        (C),
        .load     (load),
        .Aaddr    (Aaddr),
        .Baddr    (Baddr),
        .Ahit     (Ahit),
        .Bhit     (Bhit),
        .count    (count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Entered and left at posedge+1; holds the request until an edge accepts it.
    task automatic do_push(input logic [3:0] a, input logic [15:0] d);
        int   guard = 0;
        logic acc;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        do begin
            @(negedge clk);
            acc = wr_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 50);
        if (!acc) chk("push_timeout", 32'(acc), 32'd1);
        wr_valid = 1'b0;
    endtask

    // Scoreboard: hit prediction from queued entries, drain checks, then record accepted pushes.
    always @(negedge clk) begin
        mh_a = 1'b0;
        mh_b = 1'b0;
        foreach (exp_q[k]) begin
            if (exp_q[k].addr == Aaddr) mh_a = 1'b1;
            if (exp_q[k].addr == Baddr) mh_b = 1'b1;
        end
        chk("ahit", 32'(Ahit), 32'(mh_a & HIT));
        chk("bhit", 32'(Bhit), 32'(mh_b & HIT));
        if (load) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_load", 32'(load), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("drain_addr", 32'(Caddr), 32'(mon_e.addr));
                chk("drain_data", 32'(C), 32'(mon_e.data));
                rf_model[Caddr] = C;
            end
        end else begin
            chk("idle_zero", {12'd0, Caddr, C}, 32'd0);
        end
        if (wr_valid && wr_ready && nClear) begin
            exp_q.push_back('{addr: wr_addr, data: wr_data});
            ref_rf[wr_addr] = wr_data;
        end
    end

    initial begin
        int g;
        for (int r = 0; r < 16; r++) begin
            rf_model[r] = '0;
            ref_rf[r]   = '0;
        end

        #3;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_caddr", 32'(Caddr), 32'd0);
        chk("rst_c", 32'(C), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_ahit", 32'(Ahit), 32'd0);
        chk("rst_bhit", 32'(Bhit), 32'd0);
        @(posedge clk);
        #1;
        nClear = 1'b1;

        // Single write, one-cycle latency to the write port
        do_push(4'd3, 16'hBEEF);
        @(negedge clk);
        chk("t1_load", 32'(load), 32'd1);
        chk("t1_caddr", 32'(Caddr), 32'd3);
        chk("t1_c", 32'(C), 32'hBEEF);
        @(negedge clk);
        chk("t1_load_off", 32'(load), 32'd0);
        chk("t1_zero", {12'd0, Caddr, C}, 32'd0);
        @(posedge clk);
        #1;

        // Fill under hold, then in-order retirement
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) do_push(4'(i), 16'(i * 16'h11));
        @(negedge clk);
        chk("t2_count_full", 32'(count), 32'd4);
        chk("t2_wr_ready", 32'(wr_ready), 32'd0);
        chk("t2_load_held", 32'(load), 32'd0);
        @(posedge clk);
        #1;
        hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("t2_load", 32'(load), 32'd1);
            chk("t2_order", 32'(Caddr), 32'(i));
        end
        @(negedge clk);
        chk("t2_empty", 32'(count), 32'd0);
        @(posedge clk);
        #1;

        // Push into a full queue that drains the same cycle
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) do_push(4'(i), 16'(i * 16'h11));
        hold     = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 4'd5;
        wr_data  = 16'h55;
        @(negedge clk);
        chk("t3_wr_ready_full", 32'(wr_ready), 32'd1);
        chk("t3_count", 32'(count), 32'd4);
        chk("t3_head", 32'(Caddr), 32'd1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            if (k == 2) chk("t3_count_kept", 32'(count), 32'd4);
            chk("t3_order", 32'(Caddr), 32'(k));
        end
        chk("t3_fifth_data", 32'(C), 32'h55);
        @(negedge clk);
        chk("t3_done", 32'(load), 32'd0);
        @(posedge clk);
        #1;

        // Read-after-write hazard on repeated address
        Aaddr = 4'd7;
        Baddr = 4'd8;
        hold  = 1'b1;
        do_push(4'd7, 16'h1);
        do_push(4'd7, 16'h2);
        @(negedge clk);
        chk("t4_ahit_held", 32'(Ahit), 32'(HIT));
        chk("t4_bhit_held", 32'(Bhit), 32'd0);
        @(posedge clk);
        #1;
        hold = 1'b0;
        @(negedge clk);
        chk("t4_ahit_d1", 32'(Ahit), 32'(HIT));
        @(negedge clk);
        chk("t4_ahit_d2", 32'(Ahit), 32'(HIT));
        chk("t4_last_wins", 32'(C), 32'h2);
        @(negedge clk);
        chk("t4_ahit_after", 32'(Ahit), 32'd0);
        chk("t4_bhit_after", 32'(Bhit), 32'd0);
        @(posedge clk);
        #1;

        // Asynchronous clear with pending writes
        hold = 1'b1;
        do_push(4'd10, 16'hA0A0);
        do_push(4'd11, 16'hB1B1);
        do_push(4'd12, 16'hC2C2);
        @(negedge clk);
        chk("t5_count3", 32'(count), 32'd3);
        @(posedge clk);
        #1;
        hold = 1'b0;
        #2;
        nClear = 1'b0;
        exp_q.delete();
        #1;
        chk("t5_clr_count", 32'(count), 32'd0);
        chk("t5_clr_load", 32'(load), 32'd0);
        chk("t5_clr_caddr", 32'(Caddr), 32'd0);
        #3;
        nClear = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_no_stale", 32'(load), 32'd0);
        end
        @(posedge clk);
        #1;

        // Random push/hold traffic scored against a register-file model
        for (int r = 0; r < 16; r++) begin
            rf_model[r] = '0;
            ref_rf[r]   = '0;
        end
        repeat (400) begin
            hold     = ($urandom_range(0, 9) < 3);
            wr_valid = ($urandom_range(0, 9) < 6);
            wr_addr  = 4'($urandom);
            wr_data  = 16'($urandom);
            Aaddr    = 4'($urandom);
            Baddr    = 4'($urandom);
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0;
        hold     = 1'b0;
        g = 0;
        while (count != 0 && g < 40) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("t6_drained", 32'(count), 32'd0);
        @(negedge clk);
        chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);
        for (int r = 0; r < 16; r++) chk("t6_regfile", 32'(rf_model[r]), 32'(ref_rf[r]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
